// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: ALU results take the port, queued loads fill idle cycles.
// Optional WB_LOAD_BYPASS_EN: a load arriving to an idle port with an empty FIFO is written directly.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       areset_n,
  input  logic       alu_valid,
  input  logic [1:0] alu_sel,
  input  logic [7:0] alu_data,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [1:0] ld_sel,
  input  logic [7:0] ld_data,
  output logic       write_bit,
  output logic [1:0] selector_e,
  output logic [7:0] data_in,
  output logic [3:0] ld_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic          r_valid [DEPTH];
  logic [1:0]    r_sel   [DEPTH];
  logic [7:0]    r_data  [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          r_we;
  logic [1:0]    r_wsel;
  logic [7:0]    r_wdata;

  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_bypass;
  logic          w_conflict;
  logic          w_push;
  logic          w_we_nxt;
  logic [1:0]    w_sel_nxt;
  logic [7:0]    w_data_nxt;

  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count >= CW'(DEPTH));
    ld_ready   = areset_n && !w_full;
    w_accept   = ld_valid && ld_ready;
    w_pop      = !alu_valid && !w_empty;
    w_conflict = alu_valid && (ld_sel == alu_sel);
`ifdef WB_LOAD_BYPASS_EN
    w_bypass   = w_accept && !alu_valid && w_empty;
`else
    w_bypass   = 1'b0;
`endif
    w_push     = w_accept && !w_conflict && !w_bypass;
  end

  // Squashed heads still consume a pop cycle but leave the address/data lines untouched.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_sel_nxt  = r_wsel;
    w_data_nxt = r_wdata;
    if (alu_valid) begin
      w_we_nxt   = 1'b1;
      w_sel_nxt  = alu_sel;
      w_data_nxt = alu_data;
    end else if (!w_empty) begin
      if (r_valid[r_rd_ptr]) begin
        w_we_nxt   = 1'b1;
        w_sel_nxt  = r_sel[r_rd_ptr];
        w_data_nxt = r_data[r_rd_ptr];
      end
    end else if (w_bypass) begin
      w_we_nxt   = 1'b1;
      w_sel_nxt  = ld_sel;
      w_data_nxt = ld_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!areset_n) begin
      r_we    <= 1'b0;
      r_wsel  <= 2'd0;
      r_wdata <= 8'd0;
    end else begin
      r_we    <= w_we_nxt;
      r_wsel  <= w_sel_nxt;
      r_wdata <= w_data_nxt;
    end
  end

  // Pop and push never touch the same slot: that would need count 0 with a pop or count DEPTH with a push.
  always_ff @(posedge CLK) begin
    if (!areset_n) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (alu_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_sel[i] == alu_sel) r_valid[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_sel[r_wr_ptr]  <= ld_sel;
      r_data[r_wr_ptr] <= ld_data;
    end
  end

  always_comb begin
    ld_pending = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) ld_pending[r_sel[i]] = 1'b1;
    end
  end

  assign write_bit  = r_we;
  assign selector_e = r_wsel;
  assign data_in    = r_wdata;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed plus randomized bench for regfile_writeback against a queue-based reference model.
// Honours WB_LOAD_BYPASS_EN when the design is built with it.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       areset_n;
  logic       alu_valid;
  logic [1:0] alu_sel;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic       write_bit;
  logic [1:0] selector_e;
  logic [7:0] data_in;
  logic [3:0] ld_pending;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .areset_n  (areset_n),
    .alu_valid (alu_valid),
    .alu_sel   (alu_sel),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_data   (ld_data),
    .write_bit (write_bit),
    .selector_e(selector_e),
    .data_in   (data_in),
    .ld_pending(ld_pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       v;
    bit [1:0] s;
    bit [7:0] d;
  } ent_t;

  ent_t     q[$];
  bit       m_we;
  bit [1:0] m_sel;
  bit [7:0] m_data;
  int       n_vec;
  int       n_err;

  function automatic bit m_ready(input bit rst_n);
    return rst_n && (q.size() < DEPTH);
  endfunction

  function automatic logic [3:0] m_pending();
    logic [3:0] p;
    p = 4'b0000;
    foreach (q[i]) if (q[i].v) p[q[i].s] = 1'b1;
    return p;
  endfunction

  task automatic m_edge(input bit rst_n, input bit av, input bit [1:0] as, input bit [7:0] ad,
                        input bit lv, input bit [1:0] ls, input bit [7:0] ldd);
    bit   acc;
    bit   byp;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_we = 0; m_sel = 0; m_data = 0;
      return;
    end
    acc = lv && (q.size() < DEPTH);
    byp = 0;
`ifdef WB_LOAD_BYPASS_EN
    byp = acc && !av && (q.size() == 0);
`endif
    if (av) begin
      m_we = 1; m_sel = as; m_data = ad;
      foreach (q[i]) if (q[i].s == as) q[i].v = 0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.v;
      if (e.v) begin
        m_sel = e.s; m_data = e.d;
      end
    end else if (byp) begin
      m_we = 1; m_sel = ls; m_data = ldd;
    end else begin
      m_we = 0;
    end
    if (acc && !byp && !(av && ls == as)) begin
      e.v = 1; e.s = ls; e.d = ldd;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check ready before the edge and registered outputs after it.
  task automatic step(input bit rst_n, input bit av, input bit [1:0] as, input bit [7:0] ad,
                      input bit lv, input bit [1:0] ls, input bit [7:0] ldd);
    areset_n  = rst_n;
    alu_valid = av; alu_sel = as; alu_data = ad;
    ld_valid  = lv; ld_sel  = ls; ld_data  = ldd;
    #1;
    chk("ld_ready", 8'(ld_ready), 8'(m_ready(rst_n)));
    @(posedge CLK);
    m_edge(rst_n, av, as, ad, lv, ls, ldd);
    #1;
    chk("write_bit", 8'(write_bit), 8'(m_we));
    if (m_we) begin
      chk("selector_e", 8'(selector_e), 8'(m_sel));
      chk("data_in", data_in, m_data);
    end
    chk("ld_pending", 8'(ld_pending), 8'(m_pending()));
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_we = 0; m_sel = 0; m_data = 0;
    areset_n = 0; alu_valid = 0; alu_sel = 0; alu_data = 0;
    ld_valid = 0; ld_sel = 0; ld_data = 0;
    @(negedge CLK);

    // reset with both requesters active
    step(0, 1, 2'd1, 8'hC3, 1, 2'd2, 8'h3C);
    step(0, 1, 2'd1, 8'hC3, 1, 2'd2, 8'h3C);
    chk("rst_we", 8'(write_bit), 8'h00);
    chk("rst_sel", 8'(selector_e), 8'h00);
    chk("rst_data", data_in, 8'h00);
    chk("rst_pend", 8'(ld_pending), 8'h00);
    chk("rst_ready", 8'(ld_ready), 8'h00);
    areset_n = 1; alu_valid = 0; ld_valid = 0;
    #1;
    chk("rel_ready", 8'(ld_ready), 8'h01);
    @(negedge CLK);

    // ALU only
    step(1, 1, 2'd2, 8'h5A, 0, 0, 0);
    chk("alu_we", 8'(write_bit), 8'h01);
    chk("alu_sel", 8'(selector_e), 8'h02);
    chk("alu_data", data_in, 8'h5A);
    idle();
    chk("alu_we_off", 8'(write_bit), 8'h00);

    // load latency
    step(1, 0, 0, 0, 1, 2'd1, 8'h33);
`ifdef WB_LOAD_BYPASS_EN
    chk("byp_we", 8'(write_bit), 8'h01);
    chk("byp_data", data_in, 8'h33);
    chk("byp_pend", 8'(ld_pending), 8'h00);
    idle();
`else
    chk("ld_we_early", 8'(write_bit), 8'h00);
    chk("ld_pend", 8'(ld_pending), 8'h02);
    idle();
    chk("ld_we", 8'(write_bit), 8'h01);
    chk("ld_sel", 8'(selector_e), 8'h01);
    chk("ld_data", data_in, 8'h33);
`endif
    idle();

    // fill while ALU owns the port; the fourth ALU write squashes the reg0 load
    step(1, 1, 2'd3, 8'h90, 1, 2'd0, 8'h10);
    step(1, 1, 2'd3, 8'h91, 1, 2'd1, 8'h11);
    step(1, 1, 2'd3, 8'h92, 1, 2'd2, 8'h12);
    step(1, 1, 2'd0, 8'h93, 1, 2'd3, 8'h13);
    chk("full_ready", 8'(ld_ready), 8'h00);
    chk("full_pend", 8'(ld_pending), 8'h0E);
    step(1, 1, 2'd0, 8'h94, 1, 2'd1, 8'h77);
    idle();
    chk("drain0_we", 8'(write_bit), 8'h00);
    idle();
    chk("drain1_sel", 8'(selector_e), 8'h01);
    chk("drain1_data", data_in, 8'h11);
    idle();
    chk("drain2_sel", 8'(selector_e), 8'h02);
    idle();
    chk("drain3_sel", 8'(selector_e), 8'h03);
    chk("drain3_data", data_in, 8'h13);
    chk("drain_ready", 8'(ld_ready), 8'h01);
    idle();

    // squash of a queued load
    step(1, 1, 2'd0, 8'h01, 1, 2'd3, 8'h11);
    chk("sq_pend_set", 8'(ld_pending), 8'h08);
    step(1, 1, 2'd3, 8'h22, 0, 0, 0);
    chk("sq_pend_clr", 8'(ld_pending), 8'h00);
    chk("sq_data", data_in, 8'h22);
    idle();
    chk("sq_idle_we", 8'(write_bit), 8'h00);
    idle();

    // same-cycle conflict
    step(1, 1, 2'd0, 8'hBB, 1, 2'd0, 8'hAA);
    chk("cf_we", 8'(write_bit), 8'h01);
    chk("cf_data", data_in, 8'hBB);
    chk("cf_pend", 8'(ld_pending), 8'h00);
    idle();
    chk("cf_after_we", 8'(write_bit), 8'h00);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 40), 2'($urandom), 8'($urandom),
           ($urandom_range(0, 99) < 65), 2'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
